// File: rtl/enc_pkg.sv
// Shared types and helpers for the sequential 16-to-4 encoder.
// Holds the FSM state type, vector/code widths and the one-hot-or-zero test.
package enc_pkg;

    localparam int unsigned IN_W   = 16;
    localparam int unsigned CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        ZERO = 2'd2
    } state_t;

    // True when at most one bit of v is set.
    function automatic logic onehot_or_zero(input logic [IN_W-1:0] v);
        return (v & (v - IN_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/prio_enc_16_4.sv
// Combinational 16-to-4 priority encoder; LOW_FIRST selects lowest (1) or highest (0) set bit.
// found is 1 when any input bit is set; code is 0 otherwise.
module prio_enc_16_4
    import enc_pkg::*;
#(
    parameter int unsigned LOW_FIRST = 1
) (
    input  logic [IN_W-1:0]   vec,
    output logic [CODE_W-1:0] code,
    output logic              found
);

    // Later matches overwrite earlier ones, so scan towards the preferred end.
    always_comb begin
        code  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (LOW_FIRST != 0) begin
                if (vec[IN_W-1-i]) begin
                    code  = CODE_W'(IN_W - 1 - i);
                    found = 1'b1;
                end
            end else begin
                if (vec[i]) begin
                    code  = CODE_W'(i);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/enc_16_4_seq.sv
// Sequential 16-to-4 encoder: one valid/ready beat per set request bit, in scan order.
// Optional macro ENC_ZERO_BEAT_EN: an accepted all-zero request emits one out_zero beat.
module enc_16_4_seq
    import enc_pkg::*;
#(
    parameter int unsigned LOW_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   req,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CODE_W-1:0] code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_zero
);

    state_t              state, state_n;
    logic [IN_W-1:0]     pending, pending_n;
    logic [IN_W-1:0]     clr_mask;
    logic [CODE_W-1:0]   code_hold, code_hold_n;
    logic [CODE_W-1:0]   enc_code;
    logic                enc_found;
    logic                enc_last;

    prio_enc_16_4 #(
        .LOW_FIRST(LOW_FIRST)
    ) u_prio (
        .vec   (pending),
        .code  (enc_code),
        .found (enc_found)
    );

    assign enc_last = onehot_or_zero(pending);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= '0;
            code_hold <= '0;
        end else begin
            state     <= state_n;
            pending   <= pending_n;
            code_hold <= code_hold_n;
        end
    end

    // code is live from the encoder while emitting; code_hold keeps the last beat for IDLE.
    always_comb begin
        state_n     = state;
        pending_n   = pending;
        code_hold_n = code_hold;
        clr_mask    = IN_W'(1) << enc_code;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_zero    = 1'b0;
        code        = code_hold;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (req != '0) begin
                        pending_n = req;
                        state_n   = EMIT;
                    end else begin
`ifdef ENC_ZERO_BEAT_EN
                        state_n = ZERO;
`else
                        state_n = IDLE;
`endif
                    end
                end
            end

            EMIT: begin
                out_valid = enc_found;
                out_last  = enc_last;
                code      = enc_code;
                if (!enc_found) begin
                    state_n = IDLE;
                end else if (out_ready) begin
                    pending_n   = pending & ~clr_mask;
                    code_hold_n = enc_code;
                    if (enc_last) begin
                        state_n = IDLE;
                    end
                end
            end

`ifdef ENC_ZERO_BEAT_EN
            ZERO: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_zero  = 1'b1;
                code      = '0;
                if (out_ready) begin
                    code_hold_n = '0;
                    state_n     = IDLE;
                end
            end
`endif

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_enc_16_4_seq.sv
// Bench for enc_16_4_seq: both scan orders side by side, queue-based beat model plus directed scenarios.
module tb_enc_16_4_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] req;
    logic        in_valid;
    logic        out_ready;

    logic        rdy_lo, val_lo, last_lo, zero_lo;
    logic        rdy_hi, val_hi, last_hi, zero_hi;
    logic [3:0]  code_lo, code_hi;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int q_lo[$];
    int q_hi[$];
    bit zero_pend = 1'b0;
    int hold_lo   = 0;
    int hold_hi   = 0;

    always #5 clk = ~clk;

    enc_16_4_seq #(.LOW_FIRST(1)) u_lo (
        .clk(clk), .reset(reset), .req(req), .in_valid(in_valid), .in_ready(rdy_lo),
        .code(code_lo), .out_valid(val_lo), .out_ready(out_ready),
        .out_last(last_lo), .out_zero(zero_lo)
    );

    enc_16_4_seq #(.LOW_FIRST(0)) u_hi (
        .clk(clk), .reset(reset), .req(req), .in_valid(in_valid), .in_ready(rdy_hi),
        .code(code_hi), .out_valid(val_hi), .out_ready(out_ready),
        .out_last(last_hi), .out_zero(zero_hi)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted vector becomes a list of beat indices; beats pop on handshakes.
    initial begin
        bit busy;
        forever begin
            @(posedge clk);
            if (reset) begin
                q_lo.delete();
                q_hi.delete();
                zero_pend = 1'b0;
                hold_lo   = 0;
                hold_hi   = 0;
            end else if (q_lo.size() == 0 && !zero_pend) begin
                if (in_valid) begin
                    if (req != 16'h0) begin
                        for (int i = 0; i < 16; i++) begin
                            if (req[i]) begin
                                q_lo.push_back(i);
                                q_hi.push_front(i);
                            end
                        end
                    end else begin
`ifdef ENC_ZERO_BEAT_EN
                        zero_pend = 1'b1;
`endif
                    end
                end
            end else if (out_ready) begin
                if (zero_pend) begin
                    zero_pend = 1'b0;
                    hold_lo   = 0;
                    hold_hi   = 0;
                end else begin
                    hold_lo = q_lo.pop_front();
                    hold_hi = q_hi.pop_front();
                end
            end

            @(negedge clk);
            if (chk_en) begin
                busy = (q_lo.size() != 0) || zero_pend;
                chk("m_in_ready_lo", rdy_lo, !busy);
                chk("m_in_ready_hi", rdy_hi, !busy);
                chk("m_out_valid_lo", val_lo, busy);
                chk("m_out_valid_hi", val_hi, busy);
                chk("m_out_zero_lo", zero_lo, zero_pend);
                chk("m_out_zero_hi", zero_hi, zero_pend);
                if (zero_pend) begin
                    chk("m_code_lo", code_lo, 0);
                    chk("m_code_hi", code_hi, 0);
                    chk("m_last_lo", last_lo, 1);
                    chk("m_last_hi", last_hi, 1);
                end else if (busy) begin
                    chk("m_code_lo", code_lo, q_lo[0]);
                    chk("m_code_hi", code_hi, q_hi[0]);
                    chk("m_last_lo", last_lo, q_lo.size() == 1);
                    chk("m_last_hi", last_hi, q_hi.size() == 1);
                end else begin
                    chk("m_hold_code_lo", code_lo, hold_lo);
                    chk("m_hold_code_hi", code_hi, hold_hi);
                    chk("m_idle_last_lo", last_lo, 0);
                    chk("m_idle_last_hi", last_hi, 0);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the input handshake.
    task automatic send(input logic [15:0] v);
        int unsigned n = 0;
        while (!rdy_lo && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_wait", rdy_lo, 1);
        req      = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int e_lo[4];
        int e_hi[4];
        e_lo = '{0, 5, 10, 15};
        e_hi = '{15, 10, 5, 0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        req       = 16'h0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_in_ready", rdy_lo, 1);
        chk("reset_out_valid", val_lo, 0);
        chk("reset_code", code_lo, 0);
        chk_en = 1'b1;

        // Single bit: one beat, ready again two cycles after the handshake.
        send(16'h0001);
        chk("s1_valid", val_lo, 1);
        chk("s1_code", code_lo, 0);
        chk("s1_last", last_lo, 1);
        @(negedge clk);
        chk("s1_ready_again", rdy_lo, 1);

        // Sparse vector in both orders; also pins the model queue contents.
        send(16'h8421);
        chk("s2_model_len", q_lo.size(), 4);
        chk("s2_model_first", q_lo[0], 0);
        chk("s2_model_hi_first", q_hi[0], 15);
        for (int k = 0; k < 4; k++) begin
            chk("s2_code_lo", code_lo, e_lo[k]);
            chk("s2_code_hi", code_hi, e_hi[k]);
            chk("s2_last_lo", last_lo, k == 3);
            @(negedge clk);
        end
        chk("s2_done_ready", rdy_lo, 1);
        chk("s2_hold_lo", code_lo, 15);
        chk("s2_hold_hi", code_hi, 0);

        // Backpressure on the first beat.
        out_ready = 1'b0;
        send(16'h0300);
        repeat (3) begin
            chk("s3_stall_valid", val_lo, 1);
            chk("s3_stall_code", code_lo, 8);
            chk("s3_stall_last", last_lo, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("s3_beat0", code_lo, 8);
        chk("s3_beat0_hi", code_hi, 9);
        @(negedge clk);
        chk("s3_beat1", code_lo, 9);
        chk("s3_beat1_last", last_lo, 1);
        @(negedge clk);
        chk("s3_done_valid", val_lo, 0);

        // Reset in the middle of a long vector.
        send(16'hFFFF);
        for (int k = 0; k < 4; k++) begin
            chk("s4_code_lo", code_lo, k);
            chk("s4_code_hi", code_hi, 15 - k);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("s4_rst_valid", val_lo, 0);
        chk("s4_rst_ready", rdy_lo, 1);
        chk("s4_rst_code_lo", code_lo, 0);
        chk("s4_rst_code_hi", code_hi, 0);
        repeat (3) begin
            @(negedge clk);
            chk("s4_no_stale_lo", val_lo, 0);
            chk("s4_no_stale_hi", val_hi, 0);
        end

        // All-zero request.
        send(16'h0000);
`ifdef ENC_ZERO_BEAT_EN
        chk("s5_valid", val_lo, 1);
        chk("s5_zero", zero_lo, 1);
        chk("s5_last", last_lo, 1);
        chk("s5_code", code_lo, 0);
        @(negedge clk);
        chk("s5_ready_again", rdy_lo, 1);
`else
        chk("s5_valid", val_lo, 0);
        chk("s5_ready", rdy_lo, 1);
        chk("s5_zero", zero_lo, 0);
        @(negedge clk);
        chk("s5_still_idle", val_lo, 0);
`endif

        // New requests offered while emitting are ignored.
        send(16'h0007);
        in_valid = 1'b1;
        req      = 16'hF0F0;
        chk("s6_code0", code_lo, 0);
        @(negedge clk);
        req = 16'h0F0F;
        chk("s6_code1", code_lo, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("s6_code2", code_lo, 2);
        chk("s6_last", last_lo, 1);
        @(negedge clk);
        chk("s6_idle_valid", val_lo, 0);
        chk("s6_idle_code", code_lo, 2);

        // Randomized traffic checked by the model every cycle.
        repeat (800) begin
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0:       req = 16'h0000;
                1:       req = 16'(1) << $urandom_range(0, 15);
                2:       req = 16'hFFFF;
                default: req = 16'($urandom);
            endcase
            reset = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(negedge clk);
        chk("drain_idle", rdy_lo, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enc_16_4_seq.md
ENC_16_4_SEQ -- requirements
Module: enc_16_4_seq

Interface
REQ-001 Parameter: LOW_FIRST, default 1, scan order: 1 = lowest set bit first, 0 = highest set bit first.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 req  input  16  request vector to encode.
REQ-005 in_valid  input  1  req valid.
REQ-006 in_ready  output  1  block accepts req this cycle.
REQ-007 code  output  4  index of the set bit currently presented.
REQ-008 out_valid  output  1  code/out_last/out_zero valid.
REQ-009 out_ready  input  1  sink accepts the current beat.
REQ-010 out_last  output  1  current beat is the final beat for the captured vector.
REQ-011 out_zero  output  1  current beat reports an all-zero vector (see Configuration).

Function
REQ-012 The block SHALL be a registered FSM with states IDLE, EMIT and ZERO, plus a 16-bit pending register.
REQ-013 The block SHALL accept an input on a cycle where in_valid=1 and in_ready=1, i.e. an input handshake.
REQ-014 In IDLE, in_ready SHALL be 1; in EMIT and ZERO, in_ready SHALL be 0.
REQ-015 On an input handshake with req != 0, the block SHALL load pending <= req and go to EMIT; the first beat SHALL appear on the next cycle (latency 1).
REQ-016 In EMIT, the block SHALL hold out_valid=1, drive code = index of the lowest set bit of pending (LOW_FIRST=1) or the highest set bit (LOW_FIRST=0), and drive out_last=1 iff exactly one bit of pending is set.
REQ-017 The block SHALL complete an output beat on a cycle where out_valid=1 and out_ready=1, i.e. an output handshake.
REQ-018 On an output handshake in EMIT, the block SHALL clear the encoded bit in pending; if out_last=1, it SHALL go to IDLE, otherwise it SHALL stay in EMIT.
REQ-019 While out_valid=1 and out_ready=0, code, out_last and out_zero SHALL remain stable (no beat dropped or altered).
REQ-020 A vector with N set bits SHALL produce exactly N beats, in strictly monotonic index order, with out_last=1 only on beat N.
REQ-021 With no backpressure, a vector with N set bits SHALL take N+1 cycles from input handshake to the next possible input handshake.
REQ-022 In IDLE, out_valid, out_last and out_zero SHALL be 0, and code SHALL hold its last value.
REQ-023 The block SHALL ignore in_valid while not in IDLE (req not sampled).
REQ-024 req=16'hFFFF SHALL yield 16 beats: codes 0..15 when LOW_FIRST=1, codes 15..0 when LOW_FIRST=0.

Reset
REQ-025 When reset=1 at a clock edge, the block SHALL enter IDLE and set pending=0, code=0, out_valid=0, out_last=0 and out_zero=0, overriding any handshake in that cycle.
REQ-026 A reset applied mid-EMIT SHALL discard the remaining bits; no further beats SHALL be emitted for that vector.

Configuration
REQ-027 The block SHALL support the macro ENC_ZERO_BEAT_EN.
REQ-028 With ENC_ZERO_BEAT_EN defined, an accepted req=0 SHALL go to ZERO, which emits one beat with code=0, out_zero=1 and out_last=1, then returns to IDLE on the output handshake.
REQ-029 Without ENC_ZERO_BEAT_EN, an accepted req=0 SHALL be consumed silently: the block stays in IDLE, emits no beat, the ZERO state is not built, and out_zero is tied to 0.

Structure
REQ-030 Package enc_pkg SHALL hold the state typedef (IDLE, EMIT, ZERO), the constants IN_W=16 and CODE_W=4, and the function returning one-hot-or-zero for a 16-bit vector.
REQ-031 A combinational sub-module prio_enc_16_4 SHALL be instantiated to produce code plus a single-bit flag for pending; it SHALL take LOW_FIRST as a parameter.
REQ-032 Target implementation size SHALL be 120-400 lines of RTL.

Verification
REQ-033 Scenario: req=16'h0001, out_ready=1 -> one beat code=0, out_last=1; in_ready=1 again 2 cycles after the input handshake.
REQ-034 Scenario: req=16'h8421, LOW_FIRST=1 -> codes 0, 5, 10, 15, with out_last only on 15; LOW_FIRST=0 -> codes 15, 10, 5, 0.
REQ-035 Scenario: req=16'h0300, out_ready low for 3 cycles on the first beat -> code=8 held stable, then beats 8 and 9, no loss.
REQ-036 Scenario: req=16'hFFFF, reset asserted after the 4th beat -> next cycle out_valid=0, in_ready=1, code=0, and no stale beats afterwards.
REQ-037 Scenario: req=0 -> with ENC_ZERO_BEAT_EN, one beat code=0, out_zero=1, out_last=1; without it, no beat and in_ready stays 1.
REQ-038 Scenario: in_valid held high with changing req during EMIT -> those values are ignored; only the first vector's beats appear.
